// File: rtl/weight_fetch_scheduler_if.sv
// Bundle of command, weight-memory and array-stream signals for weight_fetch_scheduler.
//   master : scheduler side (drives mem_addr, out_*, busy/done/err)
//   slave  : surrounding host/memory/array side
// Signals: start/base_addr/num_groups/repeat_cnt/abort (command), mem_addr/mem_w1..4
//          (memory), out_valid/out_ready/out_w1..4 (array stream), busy/done/err (status).
interface weight_fetch_scheduler_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        num_groups;
  logic [7:0]        repeat_cnt;
  logic              abort;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_w1;
  logic [7:0]        mem_w2;
  logic [7:0]        mem_w3;
  logic [7:0]        mem_w4;

  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_w1;
  logic [7:0]        out_w2;
  logic [7:0]        out_w3;
  logic [7:0]        out_w4;

  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, base_addr, num_groups, repeat_cnt, abort,
    input  mem_w1, mem_w2, mem_w3, mem_w4, out_ready,
    output mem_addr, out_valid, out_w1, out_w2, out_w3, out_w4,
    output busy, done, err
  );

  modport slave (
    output start, base_addr, num_groups, repeat_cnt, abort,
    output mem_w1, mem_w2, mem_w3, mem_w4, out_ready,
    input  mem_addr, out_valid, out_w1, out_w2, out_w3, out_w4,
    input  busy, done, err
  );
endinterface

// File: rtl/weight_fetch_scheduler.sv
// Weight fetch scheduler: walks the weight memory in strides of 4 for num_groups
// groups, repeat_cnt+1 passes, and hands each 4-weight group to the systolic array
// over valid/ready. Every output is registered.
// Ports: clk, rst (async active-low), bus (weight_fetch_scheduler_if.master).
module weight_fetch_scheduler #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_DEPTH = 8,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  weight_fetch_scheduler_if.master  bus
);

  localparam int unsigned EXT_W = ADDR_W + 3;
  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        groups_q;
  logic [7:0]        grp_idx;
  logic [7:0]        pass_left;
  logic [LAT_W-1:0]  wait_cnt;

  // End-of-command address, widened so a large base cannot wrap past the check.
  logic [EXT_W-1:0]  end_addr_c;
  logic              range_err_c;

  assign end_addr_c  = EXT_W'(bus.base_addr) + EXT_W'({bus.num_groups, 2'b00});
  assign range_err_c = end_addr_c > EXT_W'(MEM_DEPTH);

  // Command sequencer and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      base_q        <= '0;
      groups_q      <= '0;
      grp_idx       <= '0;
      pass_left     <= '0;
      wait_cnt      <= '0;
      bus.mem_addr  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_w1    <= '0;
      bus.out_w2    <= '0;
      bus.out_w3    <= '0;
      bus.out_w4    <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            base_q    <= bus.base_addr;
            groups_q  <= bus.num_groups;
            pass_left <= bus.repeat_cnt;
            grp_idx   <= '0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b1;
            if (bus.num_groups == 8'd0) begin
              bus.done <= 1'b1;
              state    <= S_DONE;
            end else if (range_err_c) begin
              bus.err  <= 1'b1;
              bus.done <= 1'b1;
              state    <= S_DONE;
            end else begin
              bus.mem_addr <= bus.base_addr;
              state        <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (bus.abort) begin
            bus.done <= 1'b1;
            state    <= S_DONE;
          end else begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end

        // Capture the memory data on the final latency cycle.
        S_WAIT: begin
          if (bus.abort) begin
            bus.done <= 1'b1;
            state    <= S_DONE;
          end else if (wait_cnt == LAT_W'(RD_LAT - 1)) begin
            bus.out_w1    <= bus.mem_w1;
            bus.out_w2    <= bus.mem_w2;
            bus.out_w3    <= bus.mem_w3;
            bus.out_w4    <= bus.mem_w4;
            bus.out_valid <= 1'b1;
            state         <= S_PRESENT;
          end else begin
            wait_cnt <= LAT_W'(wait_cnt + 1'b1);
          end
        end

        // Abort wins over a simultaneous transfer; the group is simply dropped.
        S_PRESENT: begin
          if (bus.abort) begin
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b1;
            state         <= S_DONE;
          end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (grp_idx != 8'(groups_q - 8'd1)) begin
              grp_idx      <= 8'(grp_idx + 8'd1);
              bus.mem_addr <= ADDR_W'(bus.mem_addr + ADDR_W'(4));
              state        <= S_ISSUE;
            end else if (pass_left != 8'd0) begin
              pass_left    <= 8'(pass_left - 8'd1);
              grp_idx      <= '0;
              bus.mem_addr <= base_q;
              state        <= S_ISSUE;
            end else begin
              bus.done <= 1'b1;
              state    <= S_DONE;
            end
          end
        end

        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_scheduler.sv
// Bench for weight_fetch_scheduler: directed scenarios plus randomized commands,
// checked each cycle against a transaction-level model (queue of group addresses).
module tb_weight_fetch_scheduler;

  logic clk;
  logic rst;

  weight_fetch_scheduler_if #(.ADDR_W(16)) bus ();

  weight_fetch_scheduler #(
    .ADDR_W   (16),
    .MEM_DEPTH(8),
    .RD_LAT   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memory: 8 bytes, one-cycle registered read of four consecutive bytes.
  logic [7:0] mem [0:7];

  function automatic logic [7:0] mrd(input int a);
    if (a >= 0 && a < 8) return mem[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] grp(input int a);
    return {mrd(a), mrd(a + 1), mrd(a + 2), mrd(a + 3)};
  endfunction

  always @(posedge clk) begin
    bus.mem_w1 <= mrd(int'(bus.mem_addr));
    bus.mem_w2 <= mrd(int'(bus.mem_addr) + 1);
    bus.mem_w3 <= mrd(int'(bus.mem_addr) + 2);
    bus.mem_w4 <= mrd(int'(bus.mem_addr) + 3);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outw();
    return {bus.out_w1, bus.out_w2, bus.out_w3, bus.out_w4};
  endfunction

  // Model: command becomes a list of group addresses; a group is offered two
  // edges after the command or previous transfer, and done follows the last one.
  bit          m_busy, m_done, m_err, m_valid;
  int          gap;
  int          q[$];
  logic [15:0] m_addr;
  int          m_xfers, dut_xfers;

  int rel;
  int v_log[$];
  logic [31:0] w_log[$];
  int d_log[$];

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_valid = 0; gap = 0;
    q.delete();
    m_addr = 16'h0;
  endtask

  task automatic model_step(input bit st, input logic [15:0] ba, input int ng, input int rp,
                            input bit ab, input bit rdy);
    if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (st) begin
        m_busy = 1;
        m_err  = (ng != 0) && (int'(ba) + 4 * ng > 8);
        if (ng == 0 || m_err) begin
          m_done = 1;
        end else begin
          for (int p = 0; p <= rp; p++)
            for (int g = 0; g < ng; g++) q.push_back(int'(ba) + 4 * g);
          m_addr = ba;
          gap    = 2;
        end
      end
    end else if (ab) begin
      if (m_valid && rdy) m_xfers++;
      m_valid = 0;
      q.delete();
      m_done = 1;
    end else if (m_valid) begin
      if (rdy) begin
        m_xfers++;
        m_valid = 0;
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_done = 1;
        end else begin
          m_addr = 16'(q[0]);
          gap    = 2;
        end
      end
    end else begin
      gap--;
      if (gap == 0) m_valid = 1;
    end
  endtask

  task automatic compare();
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
    if (m_valid && q.size() > 0) chk("out_w", outw(), grp(q[0]));
  endtask

  // One clock: capture inputs seen at the edge, advance model, compare 1 ns later.
  task automatic cycle();
    bit st, ab, rdy;
    logic [15:0] ba;
    int ng, rp;
    st  = bus.start;
    ab  = bus.abort;
    rdy = bus.out_ready;
    ba  = bus.base_addr;
    ng  = int'(bus.num_groups);
    rp  = int'(bus.repeat_cnt);
    if (bus.out_valid && bus.out_ready) dut_xfers++;
    @(posedge clk);
    rel++;
    model_step(st, ba, ng, rp, ab, rdy);
    #1;
    compare();
    if (bus.out_valid) begin
      v_log.push_back(rel);
      w_log.push_back(outw());
    end
    if (bus.done) d_log.push_back(rel);
  endtask

  task automatic issue(input logic [15:0] ba, input int ng, input int rp);
    bus.start      = 1'b1;
    bus.base_addr  = ba;
    bus.num_groups = 8'(ng);
    bus.repeat_cnt = 8'(rp);
    rel = -1;
    v_log.delete();
    w_log.delete();
    d_log.delete();
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_busy || bus.busy) && n < 100) begin
      cycle();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout busy=%0b", bus.busy);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    rst = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.num_groups = '0; bus.repeat_cnt = '0;
    bus.abort = 1'b0; bus.out_ready = 1'b0;
    m_xfers = 0; dut_xfers = 0; rel = 0;
    model_reset();
    load_ramp();
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_out_w", outw(), 32'd0);
    rst = 1'b1;
    repeat (2) cycle();

    // 1: two groups, array always ready.
    bus.out_ready = 1'b1;
    issue(16'd0, 2, 0);
    repeat (8) cycle();
    chk("t1_nvalid", 32'(v_log.size()), 32'd2);
    if (v_log.size() >= 2) begin
      chk("t1_v0_edge", 32'(v_log[0]), 32'd2);
      chk("t1_w0", w_log[0], 32'h01020304);
      chk("t1_v1_edge", 32'(v_log[1]), 32'd5);
      chk("t1_w1", w_log[1], 32'h05060708);
    end
    chk("t1_ndone", 32'(d_log.size()), 32'd1);
    if (d_log.size() >= 1) chk("t1_done_edge", 32'(d_log[0]), 32'd6);
    chk("t1_err", 32'(bus.err), 32'd0);

    // 2: one group, three passes.
    x0 = dut_xfers;
    issue(16'd4, 1, 2);
    wait_idle();
    cycle();
    chk("t2_xfers", 32'(dut_xfers - x0), 32'd3);
    chk("t2_ndone", 32'(d_log.size()), 32'd1);
    chk("t2_nvalid", 32'(w_log.size()), 32'd3);
    foreach (w_log[i]) chk("t2_w", w_log[i], 32'h05060708);

    // 3: backpressure holds the first group.
    bus.out_ready = 1'b0;
    issue(16'd0, 2, 0);
    repeat (2) cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_hold_w", outw(), 32'h01020304);
    end
    bus.out_ready = 1'b1;
    cycle();
    cycle();
    chk("t3_gap_valid", 32'(bus.out_valid), 32'd0);
    cycle();
    chk("t3_second_w", outw(), 32'h05060708);
    wait_idle();
    cycle();

    // 4: range error, then cleared by a good start.
    issue(16'd6, 1, 0);
    chk("t4_err", 32'(bus.err), 32'd1);
    chk("t4_done", 32'(bus.done), 32'd1);
    cycle();
    cycle();
    chk("t4_err_hold", 32'(bus.err), 32'd1);
    chk("t4_novalid", 32'(v_log.size()), 32'd0);
    issue(16'd0, 1, 0);
    chk("t4_err_clear", 32'(bus.err), 32'd0);
    wait_idle();
    cycle();

    // 5: zero groups, then a start while busy is ignored.
    issue(16'd0, 0, 0);
    chk("t5_done", 32'(bus.done), 32'd1);
    cycle();
    cycle();
    x0 = dut_xfers;
    issue(16'd0, 2, 1);
    bus.start = 1'b1; bus.base_addr = 16'd4; bus.num_groups = 8'd1; bus.repeat_cnt = 8'd0;
    cycle();
    cycle();
    bus.start = 1'b0;
    wait_idle();
    cycle();
    chk("t5_xfers", 32'(dut_xfers - x0), 32'd4);

    // 6a: asynchronous reset while presenting.
    bus.out_ready = 1'b0;
    issue(16'd0, 1, 0);
    repeat (3) cycle();
    chk("t6_pre_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    model_reset();
    #2 rst = 1'b1;
    cycle();

    // 6b: abort during the read-latency wait.
    issue(16'd0, 1, 0);
    cycle();
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    chk("t6_abort_done", 32'(bus.done), 32'd1);
    repeat (3) cycle();
    chk("t6_abort_novalid", 32'(v_log.size()), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      int r;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.abort     = ($urandom_range(0, 59) == 0);
      bus.start     = ($urandom_range(0, 5) == 0);
      r = int'($urandom_range(0, 11));
      bus.base_addr  = (r == 0) ? 16'hFFFE : 16'($urandom_range(0, 8));
      bus.num_groups = 8'($urandom_range(0, 3));
      bus.repeat_cnt = 8'($urandom_range(0, 2));
      if (!m_busy && !bus.start && $urandom_range(0, 3) == 0)
        for (int k = 0; k < 8; k++) mem[k] = 8'($urandom_range(0, 255));
      cycle();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();
    cycle();
    chk("rand_xfers", 32'(dut_xfers), 32'(m_xfers));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
